// File: rtl/portcullis_pkg.sv
// Shared definitions for the portcullis scheduler: state encoding and default timing.
package portcullis_pkg;

  typedef enum logic [2:0] {
    StHoming   = 3'd0,
    StClosed   = 3'd1,
    StRaising  = 3'd2,
    StOpenHold = 3'd3,
    StLowering = 3'd4,
    StDead     = 3'd5,
    StFault    = 3'd6
  } state_e;

  localparam int unsigned DefNReq      = 2;
  localparam int unsigned DefCntW      = 8;
  localparam int unsigned DefDeadCyc   = 4;
  localparam int unsigned DefTravelMax = 64;
  localparam int unsigned DefHoldCyc   = 32;

endpackage

// File: rtl/portcullis_rr_arb.sv
// Round-robin pick among pending open requests; pointer advances past the winner on grant.
module portcullis_rr_arb
  import portcullis_pkg::*;
#(
  parameter int unsigned N_REQ = DefNReq
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_en,
  output logic [N_REQ-1:0] gnt
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     idx;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    // Scan from the pointer upward, wrapping, and take the first set bit.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr_q) + i) % N_REQ;
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!found && (j == idx) && req[j]) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          ptr_d  = (j == N_REQ - 1) ? '0 : PtrW'(j + 1);
        end
      end
    end
    if (!gnt_en || !found) begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/portcullis_sched.sv
// Portcullis motor scheduler: arbitrates station open/close requests and sequences the
// motor with dead time, travel watchdog, auto-close hold and fault latch.
module portcullis_sched
  import portcullis_pkg::*;
#(
  parameter int unsigned N_REQ      = DefNReq,
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned DEAD_CYC   = DefDeadCyc,
  parameter int unsigned TRAVEL_MAX = DefTravelMax,
  parameter int unsigned HOLD_CYC   = DefHoldCyc
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] REQ_OPEN,
  input  logic [N_REQ-1:0] REQ_CLOSE,
  input  logic             UP_LMT,
  input  logic             DW_LMT,
  input  logic             FAULT_CLR,
  output logic             MOT_UP,
  output logic             MOT_DW,
  output logic [N_REQ-1:0] GNT,
  output logic             IS_OPEN,
  output logic             IS_CLOSED,
  output logic             FAULT
);

  if (TRAVEL_MAX >= 2**CNT_W || HOLD_CYC >= 2**CNT_W || DEAD_CYC >= 2**CNT_W ||
      TRAVEL_MAX == 0 || HOLD_CYC == 0 || DEAD_CYC == 0) begin : g_bad_timing
    $error("portcullis_sched: timing constants must be nonzero and fit in CNT_W bits");
  end

  // Each timed state lasts exactly its constant in cycles.
  localparam logic [CNT_W-1:0] TravelLast = CNT_W'(TRAVEL_MAX - 1);
  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DeadLast   = CNT_W'(DEAD_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [N_REQ-1:0] open_pend_q, open_pend_d, close_pend_q, close_pend_d;
  logic [N_REQ-1:0] open_eff, close_eff, arb_gnt, gnt_q;
  logic             dir_up_q, dir_up_d;
  logic             grant_en, clr_close, clr_all;
  logic             open_any, close_any, travel_exp;
  logic             mot_up_d, mot_dw_d, is_open_d, is_closed_d, fault_d;
  logic             mot_up_q, mot_dw_q, is_open_q, is_closed_q, fault_q;

  // Same-cycle pulses are folded in so a request is acted on the cycle it arrives.
  assign open_eff   = open_pend_q | REQ_OPEN;
  assign close_eff  = close_pend_q | REQ_CLOSE;
  assign open_any   = |open_eff;
  assign close_any  = |close_eff;
  assign travel_exp = (timer_q >= TravelLast);

  portcullis_rr_arb #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (open_eff),
    .gnt_en(grant_en),
    .gnt   (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StHoming;
      timer_q      <= '0;
      dir_up_q     <= 1'b0;
      open_pend_q  <= '0;
      close_pend_q <= '0;
      gnt_q        <= '0;
      mot_up_q     <= 1'b0;
      mot_dw_q     <= 1'b0;
      is_open_q    <= 1'b0;
      is_closed_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dir_up_q     <= dir_up_d;
      open_pend_q  <= open_pend_d;
      close_pend_q <= close_pend_d;
      if (grant_en) begin
        gnt_q <= arb_gnt;
      end
      mot_up_q     <= mot_up_d;
      mot_dw_q     <= mot_dw_d;
      is_open_q    <= is_open_d;
      is_closed_q  <= is_closed_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);
    dir_up_d  = dir_up_q;
    grant_en  = 1'b0;
    clr_close = 1'b0;
    clr_all   = 1'b0;
    case (state_q)
      StHoming: begin
        if (DW_LMT) begin
          state_d = StClosed;
          timer_d = '0;
        end else if (travel_exp) begin
          state_d = StFault;
        end
      end
      StClosed: begin
        clr_close = 1'b1;
        if (open_any) begin
          grant_en = 1'b1;
          state_d  = StRaising;
          timer_d  = '0;
        end
      end
      StRaising: begin
        // Limit wins over close: an arrived gate then lowers from OPEN_HOLD instead.
        if (UP_LMT) begin
          state_d = StOpenHold;
          timer_d = '0;
        end else if (close_any) begin
          clr_close = 1'b1;
          dir_up_d  = 1'b0;
          state_d   = StDead;
          timer_d   = '0;
        end else if (travel_exp) begin
          state_d = StFault;
        end
      end
      StOpenHold: begin
        if (close_any) begin
          clr_close = 1'b1;
          state_d   = StLowering;
          timer_d   = '0;
        end else if (open_any) begin
          grant_en = 1'b1;
          timer_d  = '0;
        end else if (timer_q >= HoldLast) begin
          state_d = StLowering;
          timer_d = '0;
        end
      end
      StLowering: begin
        clr_close = 1'b1;
        if (DW_LMT) begin
          state_d = StClosed;
          timer_d = '0;
        end else if (open_any && !close_any) begin
          grant_en = 1'b1;
          dir_up_d = 1'b1;
          state_d  = StDead;
          timer_d  = '0;
        end else if (travel_exp) begin
          state_d = StFault;
        end
      end
      StDead: begin
        if (timer_q >= DeadLast) begin
          state_d = dir_up_q ? StRaising : StLowering;
          timer_d = '0;
        end
      end
      StFault: begin
        clr_all = 1'b1;
        if (FAULT_CLR && !(UP_LMT && DW_LMT)) begin
          state_d = StHoming;
          timer_d = '0;
        end
      end
      default: begin
        state_d = StFault;
        timer_d = '0;
      end
    endcase
    // Both limits active is a sensor error regardless of state.
    if (state_q != StFault && UP_LMT && DW_LMT) begin
      state_d  = StFault;
      timer_d  = '0;
      grant_en = 1'b0;
    end
  end

  always_comb begin
    open_pend_d  = open_eff & ~(grant_en ? arb_gnt : '0);
    close_pend_d = clr_close ? '0 : close_eff;
    if (clr_all) begin
      open_pend_d  = '0;
      close_pend_d = '0;
    end
  end

  always_comb begin
    mot_up_d    = (state_d == StRaising);
    mot_dw_d    = (state_d == StHoming) || (state_d == StLowering);
    is_open_d   = (state_d == StOpenHold);
    is_closed_d = (state_d == StClosed);
    fault_d     = (state_d == StFault);
  end

  assign MOT_UP    = mot_up_q;
  assign MOT_DW    = mot_dw_q;
  assign GNT       = gnt_q;
  assign IS_OPEN   = is_open_q;
  assign IS_CLOSED = is_closed_q;
  assign FAULT     = fault_q;

endmodule

// File: tb/tb_portcullis_sched.sv
// Directed self-checking bench for portcullis_sched with hand-computed expectations.
module tb_portcullis_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_open, req_close;
  logic       up_lmt, dw_lmt, fault_clr;
  logic       mot_up, mot_dw, is_open, is_closed, fault;
  logic [1:0] gnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  portcullis_sched #(
    .N_REQ     (2),
    .CNT_W     (8),
    .DEAD_CYC  (4),
    .TRAVEL_MAX(64),
    .HOLD_CYC  (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .REQ_OPEN (req_open),
    .REQ_CLOSE(req_close),
    .UP_LMT   (up_lmt),
    .DW_LMT   (dw_lmt),
    .FAULT_CLR(fault_clr),
    .MOT_UP   (mot_up),
    .MOT_DW   (mot_dw),
    .GNT      (gnt),
    .IS_OPEN  (is_open),
    .IS_CLOSED(is_closed),
    .FAULT    (fault)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input logic dw);
    @(negedge clk);
    rst = 1'b0; req_open = '0; req_close = '0; up_lmt = 1'b0; dw_lmt = dw; fault_clr = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    n_cmp++;
    if ({mot_up, mot_dw, fault, is_open, is_closed, gnt} !== 7'b0) begin
      $display("FAIL reset_outputs: got %b want %b",
               {mot_up, mot_dw, fault, is_open, is_closed, gnt}, 7'b0);
      n_bad++;
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      n_cmp++;
      if ({mot_dw, is_closed} !== 2'b10) begin
        $display("FAIL homing_cycle%0d: got dw/closed %b want 10", k, {mot_dw, is_closed});
        n_bad++;
      end
    end
    dw_lmt = 1'b1;
    cyc(1);
    n_cmp++;
    if ({is_closed, mot_up, mot_dw} !== 3'b100) begin
      $display("FAIL homing_to_closed: got closed/up/dw %b want 100", {is_closed, mot_up, mot_dw});
      n_bad++;
    end
  endtask

  task automatic test_homing_timeout();
    apply_reset(1'b0);
    cyc(63);
    n_cmp++;
    if ({fault, mot_dw} !== 2'b01) begin
      $display("FAIL homing_before_timeout: got fault/dw %b want 01", {fault, mot_dw});
      n_bad++;
    end
    cyc(1);
    n_cmp++;
    if ({fault, mot_dw} !== 2'b10) begin
      $display("FAIL homing_timeout: got fault/dw %b want 10", {fault, mot_dw});
      n_bad++;
    end
    dw_lmt = 1'b1; fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    n_cmp++;
    if ({fault, mot_dw} !== 2'b01) begin
      $display("FAIL fault_clear_homing: got fault/dw %b want 01", {fault, mot_dw});
      n_bad++;
    end
  endtask

  task automatic test_fair_arb();
    apply_reset(1'b1);
    cyc(1);
    req_open = 2'b11;
    cyc(1);
    req_open = 2'b00;
    n_cmp++;
    if ({gnt, mot_up} !== 3'b011) begin
      $display("FAIL arb_first_grant: got gnt/up %b want 011", {gnt, mot_up});
      n_bad++;
    end
    dw_lmt = 1'b0; up_lmt = 1'b1;
    cyc(1);
    n_cmp++;
    if ({is_open, mot_up, gnt} !== 4'b1001) begin
      $display("FAIL arb_open_entry: got open/up/gnt %b want 1001", {is_open, mot_up, gnt});
      n_bad++;
    end
    cyc(1);
    n_cmp++;
    if ({gnt, is_open} !== 3'b101) begin
      $display("FAIL arb_second_grant: got gnt/open %b want 101", {gnt, is_open});
      n_bad++;
    end
    cyc(31);
    n_cmp++;
    if ({is_open, mot_dw} !== 2'b10) begin
      $display("FAIL hold_restart: got open/dw %b want 10", {is_open, mot_dw});
      n_bad++;
    end
    cyc(1);
    n_cmp++;
    if (mot_dw !== 1'b1) begin
      $display("FAIL hold_restart_expiry: got dw %b want 1", mot_dw);
      n_bad++;
    end
  endtask

  task automatic test_auto_close();
    up_lmt = 1'b0; dw_lmt = 1'b1;
    cyc(1);
    req_open = 2'b01;
    cyc(1);
    req_open = 2'b00;
    n_cmp++;
    if ({gnt, mot_up} !== 3'b011) begin
      $display("FAIL autoclose_raise: got gnt/up %b want 011", {gnt, mot_up});
      n_bad++;
    end
    up_lmt = 1'b1; dw_lmt = 1'b0;
    cyc(1);
    cyc(31);
    n_cmp++;
    if ({is_open, mot_dw} !== 2'b10) begin
      $display("FAIL autoclose_early: got open/dw %b want 10", {is_open, mot_dw});
      n_bad++;
    end
    cyc(1);
    n_cmp++;
    if ({is_open, mot_dw} !== 2'b01) begin
      $display("FAIL autoclose_32: got open/dw %b want 01", {is_open, mot_dw});
      n_bad++;
    end
    up_lmt = 1'b0; dw_lmt = 1'b1;
    cyc(1);
    n_cmp++;
    if ({is_closed, mot_dw} !== 2'b10) begin
      $display("FAIL autoclose_closed: got closed/dw %b want 10", {is_closed, mot_dw});
      n_bad++;
    end
  endtask

  task automatic test_reversal();
    req_open = 2'b10;
    cyc(1);
    req_open = 2'b00;
    n_cmp++;
    if ({gnt, mot_up} !== 3'b101) begin
      $display("FAIL rev_raise: got gnt/up %b want 101", {gnt, mot_up});
      n_bad++;
    end
    dw_lmt = 1'b0;
    cyc(1);
    req_close = 2'b10;
    cyc(1);
    req_close = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) cyc(1);
      n_cmp++;
      if ({mot_up, mot_dw} !== 2'b00) begin
        $display("FAIL rev_dead%0d: got up/dw %b want 00", k, {mot_up, mot_dw});
        n_bad++;
      end
    end
    cyc(1);
    n_cmp++;
    if ({mot_up, mot_dw} !== 2'b01) begin
      $display("FAIL rev_lower: got up/dw %b want 01", {mot_up, mot_dw});
      n_bad++;
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      n_cmp++;
      if ((mot_up & mot_dw) !== 1'b0) begin
        $display("FAIL rev_exclusive: got up&dw %b want 0", mot_up & mot_dw);
        n_bad++;
      end
    end
  endtask

  task automatic test_close_priority();
    dw_lmt = 1'b1;
    cyc(1);
    req_open = 2'b01;
    cyc(1);
    req_open = 2'b00;
    up_lmt = 1'b1; dw_lmt = 1'b0;
    cyc(1);
    n_cmp++;
    if (is_open !== 1'b1) begin
      $display("FAIL prio_open: got open %b want 1", is_open);
      n_bad++;
    end
    req_open = 2'b01; req_close = 2'b10;
    cyc(1);
    req_open = 2'b00; req_close = 2'b00;
    n_cmp++;
    if ({is_open, mot_dw} !== 2'b01) begin
      $display("FAIL prio_close_wins: got open/dw %b want 01", {is_open, mot_dw});
      n_bad++;
    end
    up_lmt = 1'b1; dw_lmt = 1'b1;
    cyc(1);
    n_cmp++;
    if ({fault, mot_dw, mot_up} !== 3'b100) begin
      $display("FAIL sensor_fault: got fault/dw/up %b want 100", {fault, mot_dw, mot_up});
      n_bad++;
    end
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    n_cmp++;
    if (fault !== 1'b1) begin
      $display("FAIL fault_clr_blocked: got fault %b want 1", fault);
      n_bad++;
    end
    up_lmt = 1'b0; dw_lmt = 1'b0; fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    n_cmp++;
    if ({fault, mot_dw} !== 2'b01) begin
      $display("FAIL fault_clr_homing: got fault/dw %b want 01", {fault, mot_dw});
      n_bad++;
    end
  endtask

  task automatic test_reset_mid();
    dw_lmt = 1'b1;
    cyc(1);
    req_open = 2'b10;
    cyc(1);
    req_open = 2'b00;
    dw_lmt = 1'b0;
    req_open = 2'b01;
    cyc(1);
    req_open = 2'b00;
    n_cmp++;
    if ({mot_up, gnt} !== 3'b110) begin
      $display("FAIL mid_raising: got up/gnt %b want 110", {mot_up, gnt});
      n_bad++;
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({mot_up, gnt} !== 3'b000) begin
      $display("FAIL mid_async_reset: got up/gnt %b want 000", {mot_up, gnt});
      n_bad++;
    end
    @(negedge clk);
    rst = 1'b1;
    cyc(1);
    n_cmp++;
    if ({mot_dw, mot_up, gnt} !== 4'b1000) begin
      $display("FAIL mid_homing: got dw/up/gnt %b want 1000", {mot_dw, mot_up, gnt});
      n_bad++;
    end
    dw_lmt = 1'b1;
    cyc(1);
    cyc(3);
    n_cmp++;
    if ({is_closed, mot_up, gnt} !== 4'b1000) begin
      $display("FAIL mid_pending_cleared: got closed/up/gnt %b want 1000",
               {is_closed, mot_up, gnt});
      n_bad++;
    end
  endtask

  initial begin
    rst = 1'b0; req_open = '0; req_close = '0; up_lmt = 1'b0; dw_lmt = 1'b0; fault_clr = 1'b0;
    test_reset();
    test_homing_timeout();
    test_fair_arb();
    test_auto_close();
    test_reversal();
    test_close_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/portcullis_sched.md
Name: portcullis_sched

Overview:
- Schedules the single portcullis motor between N guard stations. Each station can request open or close.
- Arbitrates open requests round-robin; close requests always take priority (fail-safe).
- Drives registered MOT_UP/MOT_DW with a reversal dead time, a travel watchdog, an auto-close hold timer and a fault latch.
- Sits above the motor drivers and limit switches, replacing the single-button A interface.

Parameters:
- N_REQ, 2, number of guard stations.
- CNT_W, 8, width of the shared timer counter.
- DEAD_CYC, 4, cycles with both motors off before any direction reversal.
- TRAVEL_MAX, 64, maximum cycles in RAISING/LOWERING/HOMING before FAULT.
- HOLD_CYC, 32, cycles the gate stays open before auto-close.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- REQ_OPEN  in  N_REQ  per-station open request, single-cycle pulse.
- REQ_CLOSE  in  N_REQ  per-station close request, single-cycle pulse.
- UP_LMT  in  1  top limit switch, 1 = fully raised.
- DW_LMT  in  1  bottom limit switch, 1 = fully lowered.
- FAULT_CLR  in  1  fault acknowledge pulse.
- MOT_UP  out  1  raise motor enable.
- MOT_DW  out  1  lower motor enable.
- GNT  out  N_REQ  one-hot owner of the current/last open cycle.
- IS_OPEN  out  1  state OPEN_HOLD.
- IS_CLOSED  out  1  state CLOSED.
- FAULT  out  1  state FAULT.

Behaviour:
- Reset (rst=0, async): state HOMING, timer=0, pending=0, GNT=0, rr pointer=0, FAULT=0, MOT_UP=0, MOT_DW=0 (MOT_DW rises the first cycle after release).
- All outputs are registered, one cycle after the state/inputs that cause them. MOT_UP & MOT_DW is never 1.
- Pending: open_pend |= REQ_OPEN, close_pend |= REQ_CLOSE each cycle. Bits are cleared when served, so a pulse is never lost.
- Arbitration: rr_arbiter picks the first set open_pend bit at or after the pointer. On grant, GNT is updated, the pointer moves to the winner+1 (mod N_REQ), and only that bit is cleared.
- Any close_pend bit acts as a global close; all close_pend bits clear together.
- UP_LMT & DW_LMT = 1 in any non-FAULT state -> FAULT next cycle (sensor error); highest priority after reset.
- States and transitions:
  - HOMING: MOT_DW=1. On DW_LMT -> CLOSED. Timer hits TRAVEL_MAX -> FAULT. Requests stay pending.
  - CLOSED: motors off. close_pend cleared. Any open_pend -> grant -> RAISING, timer=0.
  - RAISING: MOT_UP=1. On UP_LMT -> OPEN_HOLD, timer=0. On close_pend -> DEAD (next=LOWERING). Timer hits TRAVEL_MAX -> FAULT. The UP_LMT check runs before the close check in the same cycle.
  - OPEN_HOLD: motors off. A new open_pend -> grant, timer reloads to 0 (hold extended). close_pend or timer hits HOLD_CYC-1 -> LOWERING, timer=0. Close has priority if both occur in the same cycle.
  - LOWERING: MOT_DW=1. On DW_LMT -> CLOSED. On open_pend with no close_pend -> grant -> DEAD (next=RAISING). Timer hits TRAVEL_MAX -> FAULT.
  - DEAD: motors off for DEAD_CYC cycles, then go to the stored next direction, timer=0. Requests arriving during DEAD stay pending and are evaluated in the next state.
- FAULT: motors off, FAULT=1, pending cleared and ignored. FAULT_CLR with the limits not both high -> HOMING, timer=0.
- Timer: saturates at all-ones; it is never allowed to wrap. Elaboration check: TRAVEL_MAX, HOLD_CYC and DEAD_CYC are each less than 2^CNT_W.

Decomposition:
- Shared package portcullis_pkg holds:
  - state encoding localparams: HOMING, CLOSED, RAISING, OPEN_HOLD, LOWERING, DEAD, FAULT (3-bit);
  - default timing constants.
- One sub-module, portcullis_rr_arb: combinational round-robin pick of N_REQ with a registered pointer. It has a grant-enable input and one-hot output.
- The FSM, timer and pending registers stay in portcullis_sched.

Test Plan:
- Reset sequence: reset, DW_LMT=0 for 5 cycles then 1. Expect MOT_DW=1 from the first cycle after reset, then CLOSED with IS_CLOSED=1 and motors off. Separately, hold DW_LMT=0 for 64 cycles -> FAULT=1 and MOT_DW=0.
- Fair arbitration: in CLOSED, pulse REQ_OPEN=2'b11 in one cycle. Expect GNT=01 and MOT_UP=1. Set UP_LMT=1 -> IS_OPEN. The pending station 1 is granted in OPEN_HOLD: GNT=10 and the hold timer restarts.
- Auto-close: in OPEN_HOLD with no requests, expect MOT_DW=1 exactly 32 cycles after entry. Then DW_LMT=1 -> IS_CLOSED.
- Reversal: while RAISING (UP_LMT=0), pulse REQ_CLOSE=2'b10. Expect 4 cycles with MOT_UP=MOT_DW=0, then MOT_DW=1; MOT_UP and MOT_DW are never both 1.
- Close priority and sensor error: in OPEN_HOLD, pulse REQ_OPEN=01 and REQ_CLOSE=10 in the same cycle -> LOWERING. Then assert UP_LMT=DW_LMT=1 -> FAULT next cycle. Pulse FAULT_CLR with the limits still 1 -> stays FAULT. Clear the limits, pulse FAULT_CLR -> HOMING.
- Reset mid-operation: drop rst during RAISING. MOT_UP must go to 0 asynchronously; after release expect HOMING with pending=0 and GNT=0.
